// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Control sequencer for a multi-cycle MIPS datapath. A single ALU and a
// single shared memory port are reused across the cycles of an instruction.
// This FSM decides, every cycle, what the ALU computes, where the memory
// address comes from, and which architectural registers (PC, IR, register
// file) are loaded.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset (forces IDLE, clears count)
//   opcode         instr[31:26] from the instruction register
//   funct          instr[5:0]; consumed by the ALU decoder, not by this FSM
//   zero           ALU result == 0 (branch condition, same-cycle)
//   mem_ready      shared memory completes the current request this cycle
//   mem_read       memory read request
//   mem_write      memory write request
//   iord           address select: 0 = PC, 1 = ALU-out register
//   ir_write       load instruction register
//   pc_write       load PC
//   pc_src         0 = ALU (PC+1), 1 = branch-target register, 2 = jump target
//   reg_write      register-file write enable
//   reg_dst        write address: 0 = rt, 1 = rd
//   mem_to_reg     write data: 0 = ALU-out register, 1 = memory data register
//   alu_src_a      0 = PC, 1 = rs
//   alu_src_b      0 = rt, 1 = constant 1, 2 = extImm
//   alu_sel        0 = add, 1 = by funct, 2 = by opcode, 3 = compare
//   retire         one-cycle pulse on the last cycle of each instruction
//   retired_count  retired-instruction counter, wraps at 2^CNT_W
//   state          current FSM state, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_sel,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_JUMP    = 4'd3,
        ST_BRANCH  = 4'd4,
        ST_ADDR    = 4'd5,
        ST_MEM     = 4'd6,
        ST_LOAD_WB = 4'd7,
        ST_EXEC    = 4'd8,
        ST_ALU_WB  = 4'd9
    } state_t;

    // Encodings of the mux selects, named so the state table reads clearly.
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] B_RT      = 2'd0;
    localparam logic [1:0] B_ONE     = 2'd1;
    localparam logic [1:0] B_IMM     = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_OPC   = 2'd2;
    localparam logic [1:0] ALU_CMP   = 2'd3;

    state_t state_q;
    state_t state_d;

    // Armed one edge after reset release. IDLE waits for it, so the first
    // FETCH lands on the second rising edge after reset_n goes high and the
    // datapath gets one clean cycle out of reset before the first request.
    logic run_q;

    // -------------------------------------------------------------------------
    // Instruction class decode (opcode is stable in the IR after FETCH)
    // -------------------------------------------------------------------------
    logic is_r;
    logic is_load;
    logic is_store;
    logic is_br;
    logic is_bne;
    logic is_j;

    assign is_r     = (opcode == 6'b000000);
    assign is_load  = (opcode == 6'b100011) || (opcode == 6'b100100) ||
                      (opcode == 6'b100101) || (opcode == 6'b110000);
    assign is_store = (opcode == 6'b101011) || (opcode == 6'b101001) ||
                      (opcode == 6'b101000);
    assign is_bne   = (opcode == 6'b000101);
    assign is_br    = (opcode == 6'b000100) || is_bne;
    assign is_j     = (opcode == 6'b000010);

    // funct only matters to the ALU decoder downstream (alu_sel = by funct).
    logic unused_funct;
    assign unused_funct = ^funct;

    // -------------------------------------------------------------------------
    // State register and reset-release arming flop
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every output and state_d gets a default before the case, so no
    // path through the block leaves a variable unassigned and no latch forms.
    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = B_RT;
        alu_sel    = ALU_ADD;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_q) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                // Read at PC while the ALU computes PC+1 in the same cycle.
                mem_read  = 1'b1;
                alu_src_b = B_ONE;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // ALU is otherwise idle: speculatively form PC+1+imm so a
                // branch can use it from the target register next cycle.
                alu_src_b = B_IMM;
                if (is_j)                       state_d = ST_JUMP;
                else if (is_br)                 state_d = ST_BRANCH;
                else if (is_load || is_store)   state_d = ST_ADDR;
                else                            state_d = ST_EXEC;
            end

            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_BRANCH: begin
                // rs - rt drives zero in this very cycle; pc_write follows it
                // combinationally rather than waiting for a registered flag.
                alu_src_a = 1'b1;
                alu_src_b = B_RT;
                alu_sel   = ALU_CMP;
                pc_src    = PC_BRANCH;
                pc_write  = is_bne ? !zero : zero;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                state_d   = ST_MEM;
            end

            ST_MEM: begin
                // Request is a pure function of state and opcode, so it is
                // stable for every wait cycle until mem_ready.
                iord      = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = ST_LOAD_WB;
                    end else begin
                        retire  = is_store;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_LOAD_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_EXEC: begin
                alu_src_a = 1'b1;
                if (is_r) begin
                    alu_src_b = B_RT;
                    alu_sel   = ALU_FUNCT;
                end else begin
                    alu_src_b = B_IMM;
                    alu_sel   = ALU_OPC;
                end
                state_d = ST_ALU_WB;
            end

            ST_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = 1'b0;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            // Codes 10..15 are unreachable; fall back to IDLE if one appears.
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Retired-instruction counter (wraps naturally at 2^CNT_W)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Directed bench for mips_multicycle_control. Inputs change on the falling
// edge; outputs are sampled 1 ns later, mid-cycle. Each cycle compares the
// {state, control word} against a hand-written expected value, and the
// retired count is compared after every instruction.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_control;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_sel;
    logic             retire;
    logic [CNT_W-1:0] retired_count;
    logic [3:0]       state;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_count = '0;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_sel       (alu_sel),
        .retire        (retire),
        .retired_count (retired_count),
        .state         (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] ctl;
    assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_sel, retire};

    // Packs an expected control word in the same field order as ctl.
    function automatic logic [15:0] mk(
        input logic mr, input logic mw, input logic io, input logic irw,
        input logic pcw, input logic [1:0] pcs, input logic rw,
        input logic rd, input logic m2r, input logic asa,
        input logic [1:0] asb, input logic [1:0] als, input logic ret);
        return {mr, mw, io, irw, pcw, pcs, rw, rd, m2r, asa, asb, als, ret};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, compare mid-cycle, then
    // wait for the next falling edge (the rising edge in between advances).
    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic [15:0] ctl_exp, input logic mr,
                       input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
        check(tag, {12'd0, state, ctl}, {12'd0, st, ctl_exp});
        @(negedge clock);
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            cyc("fetch_wait", 4'd1, mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,2'd0,0), 1'b0, 1'b0);
        cyc("fetch_done", 4'd1, mk(1,0,0,1,1,2'd0,0,0,0,0,2'd1,2'd0,0), 1'b1, 1'b0);
    endtask

    // mem_ready is held high in DECODE to show it is ignored there.
    task automatic do_decode();
        cyc("decode", 4'd2, mk(0,0,0,0,0,2'd0,0,0,0,0,2'd2,2'd0,0), 1'b1, 1'b0);
    endtask

    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn,
                           input logic r_type);
        opcode = op;
        funct  = fn;
        do_fetch(0);
        do_decode();
        if (r_type) begin
            cyc("exec_r", 4'd8, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd1,0), 1'b1, 1'b0);
            cyc("wb_r",   4'd9, mk(0,0,0,0,0,2'd0,1,1,0,0,2'd0,2'd0,1), 1'b0, 1'b0);
        end else begin
            cyc("exec_i", 4'd8, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd2,0), 1'b1, 1'b0);
            cyc("wb_i",   4'd9, mk(0,0,0,0,0,2'd0,1,0,0,0,2'd0,2'd0,1), 1'b0, 1'b0);
        end
        exp_count = exp_count + 1'b1;
    endtask

    task automatic run_load(input logic [5:0] op, input int fw, input int mw);
        opcode = op;
        do_fetch(fw);
        do_decode();
        cyc("addr_ld", 4'd5, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0), 1'b0, 1'b0);
        for (int i = 0; i < mw; i++)
            cyc("mem_ld_wait", 4'd6, mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0), 1'b0, 1'b0);
        cyc("mem_ld_done", 4'd6, mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0), 1'b1, 1'b0);
        cyc("load_wb", 4'd7, mk(0,0,0,0,0,2'd0,1,0,1,0,2'd0,2'd0,1), 1'b0, 1'b0);
        exp_count = exp_count + 1'b1;
    endtask

    task automatic run_store(input logic [5:0] op);
        opcode = op;
        do_fetch(0);
        do_decode();
        cyc("addr_st", 4'd5, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0), 1'b0, 1'b0);
        cyc("mem_st_wait", 4'd6, mk(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0), 1'b0, 1'b0);
        cyc("mem_st_done", 4'd6, mk(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,1), 1'b1, 1'b0);
        exp_count = exp_count + 1'b1;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic z,
                              input logic pcw);
        opcode = op;
        do_fetch(0);
        do_decode();
        cyc("branch", 4'd4, mk(0,0,0,0,pcw,2'd1,0,0,0,1,2'd0,2'd3,1), 1'b1, z);
        exp_count = exp_count + 1'b1;
    endtask

    task automatic run_jump();
        opcode = 6'b000010;
        do_fetch(0);
        do_decode();
        cyc("jump", 4'd3, mk(0,0,0,0,1,2'd2,0,0,0,0,2'd0,2'd0,1), 1'b1, 1'b0);
        exp_count = exp_count + 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset held for three cycles; mem_ready high to show it has no effect.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_ready = 1'b1;
            #1;
            check("reset_out", {12'd0, state, ctl}, 32'd0);
            check("reset_cnt", {28'd0, retired_count}, 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // IDLE before and after the first edge; FETCH after the second.
        cyc("idle0", 4'd0, 16'd0, 1'b0, 1'b0);
        cyc("idle1", 4'd0, 16'd0, 1'b0, 1'b0);

        // add then addi, zero-wait: 8 cycles, two retires.
        run_alu(6'b000000, 6'b100000, 1'b1);
        run_alu(6'b001000, 6'b000000, 1'b0);
        check("count_alu", {28'd0, retired_count}, {28'd0, exp_count});

        // lw with 2 fetch waits and 3 memory waits: 10 cycles.
        run_load(6'b100011, 2, 3);
        check("count_lw", {28'd0, retired_count}, {28'd0, exp_count});

        run_branch(6'b000100, 1'b1, 1'b1);  // beq taken
        run_branch(6'b000100, 1'b0, 1'b0);  // beq not taken
        run_branch(6'b000101, 1'b0, 1'b1);  // bne taken
        check("count_br", {28'd0, retired_count}, {28'd0, exp_count});

        run_store(6'b101000);               // sb
        run_jump();
        check("count_sj", {28'd0, retired_count}, {28'd0, exp_count});

        // sw aborted by reset while its write is pending in MEM.
        opcode = 6'b101011;
        do_fetch(0);
        do_decode();
        cyc("addr_sw", 4'd5, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0), 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("mem_sw", {12'd0, state, ctl}, {12'd0, 4'd6, mk(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0)});
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out", {12'd0, state, ctl}, 32'd0);
        check("abort_cnt", {28'd0, retired_count}, 32'd0);
        exp_count = '0;
        @(negedge clock);
        reset_n = 1'b1;
        cyc("idle2", 4'd0, 16'd0, 1'b0, 1'b0);
        cyc("idle3", 4'd0, 16'd0, 1'b0, 1'b0);

        // 16 jumps on a 4-bit counter: reaches 15, then wraps to 0.
        for (int i = 0; i < 15; i++) run_jump();
        check("count_15", {28'd0, retired_count}, 32'd15);
        run_jump();
        check("count_wrap", {28'd0, retired_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
